// File: rtl/priority_hold_sel_pkg.sv
// priority_hold_pkg: shared types, constants and helpers for priority_hold_sel.
//   AGE_W       width of each per-slot wait counter (aging build only)
//   age_t       AGE_W-bit counter type
//   clog2_min1  index width helper; never returns 0, so one source still
//               gets a 1-bit index
package priority_hold_pkg;

  localparam int AGE_W = 4;

  typedef logic [AGE_W-1:0] age_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_hold_sel_pick.sv
// priority_pick: combinational lowest-index-wins arbiter.
//   req_i  request vector, bit 0 has the highest priority
//   gnt_o  one-hot grant (all zero if nothing requests)
//   idx_o  binary index of the granted bit (0 if nothing requests)
//   any_o  at least one request present
module priority_pick
  import priority_hold_pkg::*;
#(
  parameter  int INPUTS = 19,
  localparam int IDX_W  = clog2_min1(INPUTS)
) (
  input  logic [INPUTS-1:0] req_i,
  output logic [INPUTS-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (req_i[i] && !found) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/priority_hold_sel.sv
// priority_hold_sel: per-source one-entry holding slots feeding a registered,
// fixed-priority output stage (lowest full index wins).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    per-source handshake; in_ready = slot empty (registered)
//   in_data              per-source word
//   out_valid/out_ready  output handshake; out_valid is a register
//   out_data, out_src    selected word and the index of its source
//
// Optional feature: define PRIORITY_HOLD_AGING_EN to give every slot a wait
// counter; a slot that has waited AGE_LIMIT cycles becomes urgent and the
// lowest-index urgent slot beats ordinary priority. Without the macro the
// selection is pure lowest-index and a busy low index may starve the rest.
module priority_hold_sel
  import priority_hold_pkg::*;
#(
  parameter  int INPUTS    = 19,
  parameter  int WIDTH     = 32,
  parameter  int AGE_LIMIT = 15,
  localparam int SRC_W     = clog2_min1(INPUTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [INPUTS-1:0]             in_valid,
  output logic [INPUTS-1:0]             in_ready,
  input  logic [INPUTS-1:0][WIDTH-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [SRC_W-1:0]              out_src
);

  // Range checked even when aging is off so one parameter set is valid in
  // both builds.
  if (INPUTS < 2) begin : g_bad_inputs
    $error("priority_hold_sel: INPUTS must be >= 2");
  end
  if (AGE_LIMIT < 1 || AGE_LIMIT > (2**AGE_W) - 1) begin : g_bad_age
    $error("priority_hold_sel: AGE_LIMIT out of range");
  end

  logic [INPUTS-1:0]            full_q;
  logic [INPUTS-1:0][WIDTH-1:0] data_q;
  logic                         out_valid_q;
  logic [WIDTH-1:0]             out_data_q;
  logic [SRC_W-1:0]             out_src_q;

  logic                         adv;
  logic [INPUTS-1:0]            win_oh;
  logic [SRC_W-1:0]             win_idx;
  logic                         win_any;
  logic [WIDTH-1:0]             win_data;

  // Output register is free or being drained this cycle.
  assign adv = !out_valid_q || out_ready;

  // ---------------------------------------------------------------- select
`ifdef PRIORITY_HOLD_AGING_EN
  age_t              age_q [INPUTS];
  logic [INPUTS-1:0] urgent;
  logic [INPUTS-1:0] u_gnt, n_gnt;
  logic [SRC_W-1:0]  u_idx, n_idx;
  logic              u_any, n_any;

  always_comb begin
    for (int i = 0; i < INPUTS; i++)
      urgent[i] = full_q[i] && (age_q[i] == age_t'(AGE_LIMIT));
  end

  priority_pick #(.INPUTS(INPUTS)) u_pick_urgent (
    .req_i (urgent), .gnt_o (u_gnt), .idx_o (u_idx), .any_o (u_any)
  );
  priority_pick #(.INPUTS(INPUTS)) u_pick_normal (
    .req_i (full_q), .gnt_o (n_gnt), .idx_o (n_idx), .any_o (n_any)
  );

  assign win_oh  = u_any ? u_gnt : n_gnt;
  assign win_idx = u_any ? u_idx : n_idx;
  assign win_any = n_any;  // an urgent slot is always also full

  // Age clears when the slot is empty or leaves; otherwise it counts every
  // waiting cycle (including stalls) and saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUTS; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < INPUTS; i++) begin
        if (!full_q[i] || (adv && win_oh[i]))
          age_q[i] <= '0;
        else if (age_q[i] != age_t'(AGE_LIMIT))
          age_q[i] <= age_q[i] + age_t'(1);
      end
    end
  end
`else
  priority_pick #(.INPUTS(INPUTS)) u_pick (
    .req_i (full_q), .gnt_o (win_oh), .idx_o (win_idx), .any_o (win_any)
  );
`endif

  // One-hot AND-OR mux keeps the read in range for any INPUTS.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < INPUTS; i++)
      if (win_oh[i]) win_data = win_data | data_q[i];
  end

  // ----------------------------------------------------------------- slots
  // Capture only into an empty slot and clear only a full one, so a slot can
  // never capture and be selected in the same cycle; selection sees full_q
  // from the start of the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < INPUTS; i++) begin
        if (!full_q[i]) begin
          if (in_valid[i]) begin
            full_q[i] <= 1'b1;
            data_q[i] <= in_data[i];
          end
        end else if (adv && win_oh[i]) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (adv) begin
      out_valid_q <= win_any;
      if (win_any) begin
        out_data_q <= win_data;
        out_src_q  <= win_idx;
      end
    end
  end

  assign in_ready  = ~full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: doc/priority_hold_sel.md
# priority_hold_sel

Buffered front end of the fixed-priority select path: each of INPUTS sources delivers a WIDTH-bit word through its own valid/ready handshake into a one-entry holding slot. Every cycle the lowest-index occupied slot wins, lower index meaning higher priority. The winning word is moved into a registered output stage with a valid/ready handshake and tagged with its source index. The block lets independent producers tolerate downstream backpressure without losing priority order.

## Interface
- INPUTS, 19: number of sources, ≥2.
- WIDTH, 32: data width.
- AGE_LIMIT, 15: wait-cycle threshold for promotion; used only with the aging feature, 1..2^AGE_W−1.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  [INPUTS-1:0]  per-source word valid.
- in_ready  out  [INPUTS-1:0]  per-source slot empty.
- in_data  in  [INPUTS-1:0][WIDTH-1:0]  per-source word.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts.
- out_data  out  [WIDTH-1:0]  selected word.
- out_src  out  [$clog2(INPUTS)-1:0]  index of the source that supplied out_data.

## Operation
- Slot i: full flag plus WIDTH-bit data. in_ready[i] = !full[i], driven purely from registers with no combinational path from in_valid or out_ready.
- Capture: when in_valid[i] && in_ready[i], the slot loads in_data[i] and full[i] goes to 1.
- Advance condition: adv = !out_valid || out_ready.
- Winner: the lowest-index full slot.
- On adv, if any slot is full: the winner's data loads into out_data, its index into out_src, out_valid goes to 1 and full[winner] clears.
- On adv with no slot full: out_valid goes to 0, and out_data/out_src hold their old values.
- Stall: while out_valid && !out_ready, out_data, out_src and out_valid hold stable and no slot clears.
- A slot cleared this cycle shows in_ready=1 next cycle. It cannot capture and be selected in the same cycle.
- Selection uses only slots that were full at the start of the cycle. A word captured this cycle is not eligible until the next cycle.
- Reset values:
  - all full=0, so in_ready is all ones;
  - out_valid=0, out_data=0, out_src=0;
  - age counters = 0.
- Reset asserted mid-operation discards all held words immediately, including any word in the output register.

## Timing
- Latency: word presented in cycle N, captured at edge N, eligible in N+1, out_valid in N+2 if it wins and the output can advance.
- Throughput: one word per cycle at the output. A single source is limited to one word per 2 cycles because its slot must drain before it can refill.
- Output handshake: a transfer occurs on a cycle with out_valid && out_ready. The next winner appears in the following cycle with no bubble.
- Fixed priority without aging: a continuously busy low index can starve higher indices indefinitely. This is intended behaviour.

## Configuration
- Macro PRIORITY_HOLD_AGING_EN.
- Defined:
  - each slot has an AGE_W-bit counter;
  - the counter increments each cycle the slot is full and either not selected or stalled, saturating at AGE_LIMIT;
  - the counter clears when the slot is selected or empty;
  - slots with age==AGE_LIMIT are urgent. If any urgent slot exists, the lowest-index urgent slot wins; otherwise normal lowest-index selection applies.
- Not defined: no counters exist, and selection is pure lowest-index. AGE_LIMIT is ignored.

## Structure
- Package priority_hold_pkg:
  - AGE_W (4);
  - typedef age_t of AGE_W bits;
  - function clog2_min1 used for the out_src width.
- Sub-module priority_pick: combinational, parameter INPUTS. Input is a request vector; outputs are a one-hot grant, a binary index and an any flag. It is instantiated once, or twice with aging (urgent mask and normal mask), with the final result muxed on urgent-any.

## Test plan
- Reset then idle: in_ready=all ones, out_valid=0, out_data=0, out_src=0 throughout.
- Single word: in_valid[3]=1 with 0xA5A5_0003 at cycle 0, out_ready=1 → out_valid=1, out_data=0xA5A5_0003, out_src=3 in cycle 2; in_ready[3]=0 in cycle 1 only.
- Simultaneous arrival: sources 7, 2 and 18 valid together, out_ready=1 → outputs in order src 2, 7, 18 on three consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles with src 0 and src 1 loaded → out_data and out_src stay at src 0's word; src 1 stays held (in_ready[1]=0). Raise out_ready → src 1 follows next cycle.
- Starvation without the macro: src 0 refills every other cycle, src 1 refills on alternate cycles, src 5 loaded → src 5 never output. With PRIORITY_HOLD_AGING_EN and AGE_LIMIT=3, src 5 is output after 3 waiting cycles.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and slots 4 and 9 are full → out_valid drops to 0 asynchronously; after release there is no output until new input arrives.
